fifo_unpacker: RTL and testbench

//   Width down-converter placed between two depth-2 FIFOs.

---
 rtl/fifo_unpacker.sv | 106 ++++++++++
 tb/tb_fifo_unpacker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// ============================================================================
// Module   : fifo_unpacker
// Summary  : Splits wide upstream FIFO words into RATIO narrow downstream beats
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_unpacker #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic [WIDTH*RATIO-1:0] i_src_data,
  input  logic                   i_src_empty_n,
  output logic                   o_src_deq,
  output logic [WIDTH-1:0]       o_dst_data,
  output logic                   o_dst_last,
  output logic                   o_dst_enq,
  input  logic                   i_dst_full_n,
  output logic                   o_busy
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(RATIO - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]             r_st;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH*RATIO-1:0] r_hold;

  logic                   w_send;
  logic                   w_last;
  logic                   w_enq;
  logic                   w_deq;
  logic [IDX_W-1:0]       w_slot;
  logic [WIDTH-1:0]       w_beat;

  assign w_send = (r_st == S_SEND);
  assign w_last = (r_idx == c_last_idx);
  assign w_enq  = w_send & i_dst_full_n & ~i_clr;
  // Reload on the last beat keeps the downstream stream gap-free.
  assign w_deq  = ~i_clr & i_src_empty_n & (~w_send | (w_enq & w_last));

  always_comb begin
    w_slot = (LSB_FIRST != 1'b0) ? r_idx : (c_last_idx - r_idx);
    w_beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (w_slot == IDX_W'(k)) begin
        w_beat = r_hold[k*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign o_src_deq  = rst_n & w_deq;
  assign o_dst_enq  = rst_n & w_enq;
  assign o_dst_last = rst_n & w_send & w_last;
  assign o_busy     = rst_n & w_send;
  assign o_dst_data = {WIDTH{rst_n}} & w_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_IDLE;
      r_idx  <= '0;
      r_hold <= '0;
    end else if (i_clr) begin
      r_st   <= S_IDLE;
      r_idx  <= '0;
    end else begin
      case (r_st)
        S_IDLE: begin
          if (w_deq) begin
            r_hold <= i_src_data;
            r_idx  <= '0;
            r_st   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_enq) begin
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end else if (w_deq) begin
              r_hold <= i_src_data;
              r_idx  <= '0;
            end else begin
              r_idx <= '0;
              r_st  <= S_IDLE;
            end
          end
        end
        default: begin
          r_st  <= S_IDLE;
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_unpacker.sv
// ============================================================================
// Module   : tb_fifo_unpacker
// Summary  : Scoreboard bench for fifo_unpacker (LSB/MSB order and RATIO=1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_unpacker;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clr;
  logic [31:0] i_src_data;
  logic        i_src_empty_n;
  logic        i_dst_full_n;

  logic        o_src_deq, o_dst_last, o_dst_enq, o_busy;
  logic [7:0]  o_dst_data;
  logic        m_src_deq, m_dst_last, m_dst_enq, m_busy;
  logic [7:0]  m_dst_data;

  logic [7:0]  r1_data;
  logic        r1_empty_n;
  logic        r1_deq, r1_last, r1_enq, r1_busy;
  logic [7:0]  r1_out;

  vec_t  vec [6];
  int    src_q [$];
  beat_t exp_q [$];
  beat_t exp_m [$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  s_enq, s_deq, s_last, s_busy;
  logic [7:0] s_data;

  always #5 clk = ~clk;

  fifo_unpacker #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_src_data(i_src_data),
    .i_src_empty_n(i_src_empty_n), .o_src_deq(o_src_deq), .o_dst_data(o_dst_data),
    .o_dst_last(o_dst_last), .o_dst_enq(o_dst_enq), .i_dst_full_n(i_dst_full_n),
    .o_busy(o_busy));

  fifo_unpacker #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_src_data(i_src_data),
    .i_src_empty_n(i_src_empty_n), .o_src_deq(m_src_deq), .o_dst_data(m_dst_data),
    .o_dst_last(m_dst_last), .o_dst_enq(m_dst_enq), .i_dst_full_n(i_dst_full_n),
    .o_busy(m_busy));

  fifo_unpacker #(.WIDTH(8), .RATIO(1), .LSB_FIRST(1'b1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_src_data(r1_data),
    .i_src_empty_n(r1_empty_n), .o_src_deq(r1_deq), .o_dst_data(r1_out),
    .o_dst_last(r1_last), .o_dst_enq(r1_enq), .i_dst_full_n(1'b1),
    .o_busy(r1_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    i_src_empty_n = (src_q.size() != 0);
    i_src_data    = (src_q.size() != 0) ? vec[src_q[0]].word : 32'h0;
  endtask

  // One clock: sample/score at the falling edge, retire the upstream word after the rising edge.
  task automatic cycle();
    beat_t e;
    logic  popped;
    @(negedge clk);
    s_enq = o_dst_enq; s_deq = o_src_deq; s_last = o_dst_last;
    s_busy = o_busy; s_data = o_dst_data;
    if (o_dst_enq) begin
      if (exp_q.size() == 0) check("unexpected_enq", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("lsb_beat", {23'd0, o_dst_data, o_dst_last}, {23'd0, e.d, e.l});
      end
    end
    if (m_dst_enq) begin
      if (exp_m.size() == 0) check("unexpected_enq_msb", 32'd1, 32'd0);
      else begin
        e = exp_m.pop_front();
        check("msb_beat", {23'd0, m_dst_data, m_dst_last}, {23'd0, e.d, e.l});
      end
    end
    if (o_src_deq && !i_src_empty_n) check("deq_when_empty", 32'd1, 32'd0);
    if (o_dst_enq && !i_dst_full_n)  check("enq_when_full", 32'd1, 32'd0);
    if (o_src_deq && src_q.size() != 0) begin
      exp_q.push_back('{vec[src_q[0]].b0, 1'b0});
      exp_q.push_back('{vec[src_q[0]].b1, 1'b0});
      exp_q.push_back('{vec[src_q[0]].b2, 1'b0});
      exp_q.push_back('{vec[src_q[0]].b3, 1'b1});
    end
    if (m_src_deq && src_q.size() != 0) begin
      exp_m.push_back('{vec[src_q[0]].b3, 1'b0});
      exp_m.push_back('{vec[src_q[0]].b2, 1'b0});
      exp_m.push_back('{vec[src_q[0]].b1, 1'b0});
      exp_m.push_back('{vec[src_q[0]].b0, 1'b1});
    end
    popped = o_src_deq;
    @(posedge clk);
    #1;
    if (popped && src_q.size() != 0) void'(src_q.pop_front());
    drive_src();
  endtask

  initial begin
    vec[0] = '{32'hDDCCBBAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    vec[1] = '{32'h03020100, 8'h00, 8'h01, 8'h02, 8'h03};
    vec[2] = '{32'hF00DCAFE, 8'hFE, 8'hCA, 8'h0D, 8'hF0};
    vec[3] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
    vec[4] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
    vec[5] = '{32'h87654321, 8'h21, 8'h43, 8'h65, 8'h87};

    rst_n = 1'b0; i_clr = 1'b0; i_dst_full_n = 1'b1;
    i_src_empty_n = 1'b1; i_src_data = 32'hFFFFFFFF;
    r1_empty_n = 1'b0; r1_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_deq",  {31'd0, o_src_deq}, 32'd0);
    check("rst_enq",  {31'd0, o_dst_enq}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_last", {31'd0, o_dst_last}, 32'd0);
    check("rst_data", {24'd0, o_dst_data}, 32'd0);
    rst_n = 1'b1;
    drive_src();
    cycle();

    // Single word: deq, then four consecutive beats, then idle.
    src_q.push_back(0); drive_src();
    cycle();
    check("t1_deq", {31'd0, s_deq}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t1_enq", {31'd0, s_enq}, 32'd1);
      check("t1_last", {31'd0, s_last}, {31'd0, k == 3});
    end
    cycle();
    check("t1_idle", {30'd0, s_busy, s_enq}, 32'd0);

    // Back-to-back words from the table: 12 gap-free beats, reload on each last.
    for (int v = 1; v <= 3; v++) src_q.push_back(v);
    drive_src();
    cycle();
    check("t2_first_deq", {31'd0, s_deq}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("t2_enq", {31'd0, s_enq}, 32'd1);
      if (k % 4 == 0) check("t2_deq_on_last", {31'd0, s_deq}, {31'd0, k < 12});
    end
    cycle();
    check("t2_drained", {31'd0, s_enq}, 32'd0);

    // Backpressure for three cycles while beat 1 (BB) is presented.
    src_q.push_back(0); drive_src();
    cycle();
    cycle();
    check("t3_beat0", {24'd0, s_data}, 32'h000000AA);
    i_dst_full_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_stall_enq", {31'd0, s_enq}, 32'd0);
      check("t3_stall_data", {24'd0, s_data}, 32'h000000BB);
    end
    i_dst_full_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_resume_enq", {31'd0, s_enq}, 32'd1);
    end
    cycle();
    check("t3_no_dup", {31'd0, s_enq}, 32'd0);

    // Flush after beat 1, with the next word already waiting upstream.
    src_q.push_back(4); src_q.push_back(5); drive_src();
    cycle();
    cycle();
    cycle();
    check("t4_beat1", {24'd0, s_data}, 32'h00000022);
    i_clr = 1'b1;
    cycle();
    check("t4_clr_enq", {31'd0, s_enq}, 32'd0);
    check("t4_clr_deq", {31'd0, s_deq}, 32'd0);
    i_clr = 1'b0;
    exp_q.delete(); exp_m.delete();
    cycle();
    check("t4_busy_after_clr", {31'd0, s_busy}, 32'd0);
    check("t4_next_deq", {31'd0, s_deq}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t4_next_enq", {31'd0, s_enq}, 32'd1);
    end
    cycle();

    // Asynchronous reset between edges while beat 2 is presented.
    src_q.push_back(0); src_q.push_back(1); drive_src();
    cycle();
    cycle();
    cycle();
    #1;
    check("t5_beat2", {24'd0, o_dst_data}, 32'h000000CC);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, o_busy}, 32'd0);
    check("t5_enq",  {31'd0, o_dst_enq}, 32'd0);
    check("t5_deq",  {31'd0, o_src_deq}, 32'd0);
    check("t5_data", {24'd0, o_dst_data}, 32'd0);
    exp_q.delete(); exp_m.delete(); src_q.delete(); drive_src();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t5_no_partial", {30'd0, s_enq, s_busy}, 32'd0);
    end
    check("scoreboard_empty", exp_q.size() + exp_m.size(), 32'd0);

    // RATIO=1 instance: 1-edge latency, LAST always high, full-rate reload.
    r1_empty_n = 1'b1; r1_data = 8'h5A;
    @(negedge clk);
    check("r1_deq0", {29'd0, r1_deq, r1_enq, r1_busy}, 32'd4);
    @(posedge clk); #1; r1_data = 8'hC3;
    @(negedge clk);
    check("r1_beat0", {21'd0, r1_out, r1_enq, r1_last, r1_deq}, {21'd0, 8'h5A, 3'b111});
    @(posedge clk); #1; r1_empty_n = 1'b0;
    @(negedge clk);
    check("r1_beat1", {21'd0, r1_out, r1_enq, r1_last, r1_deq}, {21'd0, 8'hC3, 3'b110});
    @(posedge clk); #1;
    @(negedge clk);
    check("r1_idle", {30'd0, r1_enq, r1_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
